dbus_arbiter: RTL and testbench

Two-master data-bus arbiter and address decoder placed between the core's data port, a second bus master (boot loader / DMA) and the shared single-port data RAM. It grants one access per cycle using round-robin priority and steers the granted access to RAM or to the GPIO output register by address region. It returns read data with fixed one-cycle latency, routed to the master that issued the read.

---
 rtl/dbus_arbiter_pkg.sv | 15 +
 rtl/dbus_arbiter_if.sv | 27 ++
 rtl/dbus_arbiter_rr_arb2.sv | 32 +++
 rtl/dbus_arbiter.sv | 132 +++++++++++++
 tb/tb_dbus_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter shared types: address regions, GPIO address, read source.
// Imported by the arbiter top and its round-robin sub-block.
package dbus_pkg;

  localparam int unsigned RAM_REGION  = 0;
  localparam int unsigned GPIO_REGION = 1;
  localparam logic [31:0] GPIO_ADDR   = 32'h0000_0400;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_GPIO = 2'd1,
    SRC_NONE = 2'd2
  } src_e;

endpackage

// File: rtl/dbus_arbiter_if.sv
// dbus_if: one data-bus master port (req/addr/we/wdata in,
// gnt/rvalid/rdata/err back). master = requester, slave = arbiter.
interface dbus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req;
  logic [AW-1:0] addr;
  logic [3:0]    we;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req, addr, we, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dbus_arbiter_rr_arb2.sv
// rr_arb2: 2-requester round-robin arbiter, one-hot grant.
// Ports: clk, rst, i_req[1:0] in; o_gnt[1:0] out (0 while rst).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // index of the requester granted most recently; 1 lets m0 win first
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (!rst) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last <= 1'b1;
    else if (|o_gnt)
      r_last <= o_gnt[1];
  end

endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: 2-master data-bus arbiter + RAM/GPIO decoder.
// Ports: clk, rst; m0/m1 (dbus_if.slave); ram_en/wr/addr/wdata out,
// ram_rdata in; gpio_o out. DBUS_GPIO_EN enables the GPIO register.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RAM_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  dbus_if.slave         m0,
  dbus_if.slave         m1,
  output logic          ram_en,
  output logic [3:0]    ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [7:0]    gpio_o
);

  logic [1:0]     w_gnt;
  logic           w_any;
  logic           w_sel;
  logic [AW-1:0]  w_addr;
  logic [3:0]     w_we;
  logic [DW-1:0]  w_wdata;
  logic [AW-11:0] w_region;
  logic           w_rd;
  src_e           w_src;
  logic           w_werr;
  logic [DW-1:0]  w_gpio_rd;
  logic [DW-1:0]  w_rdata;
  logic           w_rv0;
  logic           w_rv1;
  logic           w_rerr;

  logic           r_rv;
  logic           r_own;
  src_e           r_src;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({m1.req, m0.req}),
    .o_gnt (w_gnt)
  );

  assign m0.gnt = w_gnt[0];
  assign m1.gnt = w_gnt[1];

  assign w_any   = |w_gnt;
  assign w_sel   = w_gnt[1];
  assign w_addr  = w_sel ? m1.addr  : m0.addr;
  assign w_we    = w_sel ? m1.we    : m0.we;
  assign w_wdata = w_sel ? m1.wdata : m0.wdata;

  assign w_region = w_addr[AW-1:10];
  assign w_rd     = (w_we == 4'b0000);

  // words beyond RAM_WORDS inside the RAM region are left unmapped
  always_comb begin
    w_src = SRC_NONE;
    if (w_region == (AW-10)'(RAM_REGION) &&
        32'(w_addr[9:2]) < 32'(RAM_WORDS))
      w_src = SRC_RAM;
`ifdef DBUS_GPIO_EN
    else if (w_region == (AW-10)'(GPIO_REGION))
      w_src = SRC_GPIO;
`endif
  end

  assign ram_en    = w_any && (w_src == SRC_RAM);
  assign ram_wr    = ram_en ? w_we : 4'b0000;
  assign ram_addr  = w_addr;
  assign ram_wdata = w_wdata;

`ifdef DBUS_GPIO_EN
  logic [7:0] r_gpio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_gpio <= 8'h00;
    else if (w_any && w_src == SRC_GPIO && w_we[0])
      r_gpio <= w_wdata[7:0];
  end

  assign gpio_o    = r_gpio;
  assign w_gpio_rd = {{(DW-8){1'b0}}, r_gpio};
`else
  assign gpio_o    = 8'h00;
  assign w_gpio_rd = '0;
`endif

  // one-deep read response pipe: owner, source, valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rv  <= 1'b0;
      r_own <= 1'b0;
      r_src <= SRC_NONE;
    end else begin
      r_rv  <= w_any && w_rd;
      r_own <= w_sel;
      r_src <= w_src;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      r_src == SRC_RAM:  w_rdata = ram_rdata;
      r_src == SRC_GPIO: w_rdata = w_gpio_rd;
      default:           w_rdata = '0;
    endcase
  end

  assign w_rv0  = r_rv && !r_own;
  assign w_rv1  = r_rv &&  r_own;
  assign w_werr = !w_rd && (w_src == SRC_NONE);
  assign w_rerr = (r_src == SRC_NONE);

  assign m0.rvalid = w_rv0;
  assign m1.rvalid = w_rv1;
  assign m0.rdata  = w_rv0 ? w_rdata : '0;
  assign m1.rdata  = w_rv1 ? w_rdata : '0;

  // write errors on the grant, read errors with the response
  assign m0.err = (w_gnt[0] && w_werr) || (w_rv0 && w_rerr);
  assign m1.err = (w_gnt[1] && w_werr) || (w_rv1 && w_rerr);

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed checks of dbus_arbiter.
// RAM model returns a fixed per-word pattern one cycle after ram_en.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_wr;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [7:0]  gpio_o;

  int n_total = 0;
  int n_bad   = 0;

`ifdef DBUS_GPIO_EN
  localparam bit GPIO_ON = 1'b1;
`else
  localparam bit GPIO_ON = 1'b0;
`endif

  dbus_if #(.AW(32), .DW(32)) m0_if ();
  dbus_if #(.AW(32), .DW(32)) m1_if ();

  dbus_arbiter #(.AW(32), .DW(32), .RAM_WORDS(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .gpio_o    (gpio_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [7:0] idx);
    return (idx == 8'd4) ? 32'hDEADBEEF : (32'h1234_0000 | 32'(idx));
  endfunction

  always @(posedge clk)
    if (ram_en) ram_rdata <= ram_word(ram_addr[9:2]);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic r, input logic [31:0] a,
                      input logic [3:0] w, input logic [31:0] d);
    m0_if.req = r; m0_if.addr = a; m0_if.we = w; m0_if.wdata = d;
  endtask

  task automatic drv1(input logic r, input logic [31:0] a,
                      input logic [3:0] w, input logic [31:0] d);
    m1_if.req = r; m1_if.addr = a; m1_if.we = w; m1_if.wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drv0(1'b0, '0, 4'h0, '0);
    drv1(1'b0, '0, 4'h0, '0);
    repeat (2) tick();

    // reset state, with a request held to prove gnt is forced low
    drv0(1'b1, 32'h10, 4'h0, '0);
    drv1(1'b1, 32'h14, 4'h0, '0);
    #1;
    check("rst_gnt0", m0_if.gnt, 0);
    check("rst_gnt1", m1_if.gnt, 0);
    check("rst_rv0", m0_if.rvalid, 0);
    check("rst_rdata0", m0_if.rdata, 0);
    check("rst_err0", m0_if.err, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_gpio", gpio_o, 0);
    drv0(1'b0, '0, 4'h0, '0);
    drv1(1'b0, '0, 4'h0, '0);
    tick();
    rst = 1'b0;

    // contention: m0, m1, m0, m1 with data to owner only
    drv0(1'b1, 32'h20, 4'h0, '0);
    drv1(1'b1, 32'h24, 4'h0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_gnt0_%0d", i), m0_if.gnt, (i % 2 == 0));
      check($sformatf("cont_gnt1_%0d", i), m1_if.gnt, (i % 2 == 1));
      if (i > 0) begin
        check($sformatf("cont_rv0_%0d", i), m0_if.rvalid, (i % 2 == 1));
        check($sformatf("cont_rv1_%0d", i), m1_if.rvalid, (i % 2 == 0));
        if (i % 2 == 1) begin
          check($sformatf("cont_rd0_%0d", i), m0_if.rdata, 32'h12340008);
          check($sformatf("cont_rd1z_%0d", i), m1_if.rdata, 0);
        end else begin
          check($sformatf("cont_rd1_%0d", i), m1_if.rdata, 32'h12340009);
          check($sformatf("cont_rd0z_%0d", i), m0_if.rdata, 0);
        end
      end
      tick();
    end
    drv0(1'b0, '0, 4'h0, '0);
    drv1(1'b0, '0, 4'h0, '0);
    check("cont_tail_rv1", m1_if.rvalid, 1);
    check("cont_tail_rd1", m1_if.rdata, 32'h12340009);
    check("cont_tail_rv0", m0_if.rvalid, 0);
    tick();

    // single m0 read of 0x10
    drv0(1'b1, 32'h10, 4'h0, '0);
    #1;
    check("rd_gnt0", m0_if.gnt, 1);
    check("rd_ram_en", ram_en, 1);
    check("rd_ram_addr", ram_addr, 32'h10);
    check("rd_ram_wr", ram_wr, 0);
    tick();
    drv0(1'b0, '0, 4'h0, '0);
    check("rd_rv0", m0_if.rvalid, 1);
    check("rd_rdata0", m0_if.rdata, 32'hDEADBEEF);
    check("rd_rv1", m1_if.rvalid, 0);
    check("rd_err0", m0_if.err, 0);
    tick();

    // m1 GPIO write, then m0 GPIO read
    drv1(1'b1, 32'h400, 4'b0001, 32'h000000A5);
    #1;
    check("gw_gnt1", m1_if.gnt, 1);
    check("gw_ram_en", ram_en, 0);
    check("gw_err1", m1_if.err, !GPIO_ON);
    tick();
    drv1(1'b0, '0, 4'h0, '0);
    check("gw_gpio", gpio_o, GPIO_ON ? 32'hA5 : 32'h0);
    drv0(1'b1, 32'h400, 4'h0, '0);
    #1;
    check("gr_gnt0", m0_if.gnt, 1);
    check("gr_err_gnt", m0_if.err, 0);
    tick();
    drv0(1'b0, '0, 4'h0, '0);
    check("gr_rv0", m0_if.rvalid, 1);
    check("gr_rdata0", m0_if.rdata, GPIO_ON ? 32'hA5 : 32'h0);
    check("gr_err0", m0_if.err, !GPIO_ON);
    tick();

    // unmapped write and read at 0x800
    drv0(1'b1, 32'h800, 4'b1111, 32'hCAFEF00D);
    #1;
    check("uw_gnt0", m0_if.gnt, 1);
    check("uw_ram_en", ram_en, 0);
    check("uw_err0", m0_if.err, 1);
    tick();
    drv0(1'b1, 32'h800, 4'h0, '0);
    #1;
    check("uw_no_rv", m0_if.rvalid, 0);
    check("ur_err_gnt", m0_if.err, 0);
    check("ur_ram_en", ram_en, 0);
    tick();
    drv0(1'b0, '0, 4'h0, '0);
    check("ur_rv0", m0_if.rvalid, 1);
    check("ur_rdata0", m0_if.rdata, 0);
    check("ur_err0", m0_if.err, 1);
    tick();
    check("ur_err_gone", m0_if.err, 0);

    // back-to-back reads of 0x0 then 0x4
    drv0(1'b1, 32'h0, 4'h0, '0);
    #1;
    check("bb_gnt_a", m0_if.gnt, 1);
    tick();
    drv0(1'b1, 32'h4, 4'h0, '0);
    #1;
    check("bb_gnt_b", m0_if.gnt, 1);
    check("bb_rv_a", m0_if.rvalid, 1);
    check("bb_rd_a", m0_if.rdata, 32'h12340000);
    tick();
    drv0(1'b0, '0, 4'h0, '0);
    check("bb_rv_b", m0_if.rvalid, 1);
    check("bb_rd_b", m0_if.rdata, 32'h12340001);
    tick();
    check("bb_rv_end", m0_if.rvalid, 0);

    // reset while a read response is pending; m0 was granted last
    drv0(1'b1, 32'h10, 4'h0, '0);
    #1;
    check("mr_gnt0", m0_if.gnt, 1);
    tick();
    drv0(1'b0, '0, 4'h0, '0);
    rst = 1'b1;
    #1;
    check("mr_rv0", m0_if.rvalid, 0);
    check("mr_rdata0", m0_if.rdata, 0);
    check("mr_ram_en", ram_en, 0);
    check("mr_gpio", gpio_o, 0);
    check("mr_err0", m0_if.err, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mr_rv_after", m0_if.rvalid, 0);
    drv0(1'b1, 32'h20, 4'h0, '0);
    drv1(1'b1, 32'h24, 4'h0, '0);
    #1;
    check("mr_cont_gnt0", m0_if.gnt, 1);
    check("mr_cont_gnt1", m1_if.gnt, 0);
    tick();
    drv0(1'b0, '0, 4'h0, '0);
    drv1(1'b0, '0, 4'h0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
